mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/rv32_mem_pkg.sv | 68 ++++++
 rtl/mem_load_align.sv | 27 ++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 memory stage: funct3 access codes,
// FSM encoding, the registered memory command and lane helpers.
package rv32_mem_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Everything presented on the data-memory port besides dmem_req
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_cmd_t;

  // Unknown funct3 values fall back to a word access
  function automatic acc_size_t size_of(input logic [2:0] f3);
    if (f3 == F3_LB || f3 == F3_LBU || f3 == F3_SB)      return SZ_BYTE;
    else if (f3 == F3_LH || f3 == F3_LHU || f3 == F3_SH) return SZ_HALF;
    else                                                 return SZ_WORD;
  endfunction

  function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input acc_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so every enabled lane carries it
  function automatic logic [31:0] lane_wdata(input acc_size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed lane out of the read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  // Shift the addressed byte/halfword down to bit 0, then extend
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  data = {24'h0, lane[7:0]};
      F3_LHU:  data = {16'h0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM pipeline stage: issues one data-memory request per load/store,
// stalls the front of the pipe until the ack, aborts after TIMEOUT cycles
// and registers the write-back value.
module mem_stage
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] rs2_mem_data_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [2:0]  funct3_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_WB,
  output logic        RegWrite_WB,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  mem_state_t  state, state_nxt;
  logic [7:0]  cnt;
  dmem_cmd_t   cmd_d, cmd_q;
  acc_size_t   size;
  logic        access, is_store, aligned, wr_en;
  logic        start, finish, abort, misalign;
  logic [31:0] ld_data;

  // MemWrite wins when both controls are set
  assign access   = MemRead_MEM | MemWrite_MEM;
  assign is_store = MemWrite_MEM;
  assign size     = size_of(funct3_MEM);
  assign aligned  = is_aligned(size, alu_MEM[1:0]);
  assign wr_en    = RegWrite_MEM & (rd_MEM != 5'd0);

  assign cmd_d = '{we:    is_store,
                   addr:  {alu_MEM[31:2], 2'b00},
                   be:    lane_be(size, alu_MEM[1:0]),
                   wdata: lane_wdata(size, rs2_mem_data_MEM)};

  assign dmem_we    = cmd_q.we;
  assign dmem_addr  = cmd_q.addr;
  assign dmem_be    = cmd_q.be;
  assign dmem_wdata = cmd_q.wdata;

  // EX_MEM is frozen while stalled, so the held inputs still describe the
  // in-flight access when the ack arrives
  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .offset (alu_MEM[1:0]),
    .funct3 (funct3_MEM),
    .data   (ld_data)
  );

  // Next-state and stall decode; ack beats timeout in the same cycle
  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    start     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    misalign  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (aligned) begin
            start     = 1'b1;
            mem_stall = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == TO_CNT) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Memory port: command latched at issue and held until ack/abort
  always_ff @(posedge clk) begin
    if (!rst) begin
      dmem_req <= 1'b0;
      cmd_q    <= '0;
    end else if (start) begin
      dmem_req <= 1'b1;
      cmd_q    <= cmd_d;
    end else if (finish || abort) begin
      dmem_req <= 1'b0;
    end
  end

  // WAIT-cycle counter, cleared on issue
  always_ff @(posedge clk) begin
    if (!rst)                               cnt <= '0;
    else if (start)                         cnt <= '0;
    else if (state == ST_WAIT && !dmem_ack) cnt <= cnt + 8'd1;
  end

  // Write-back registers and one-cycle exception pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_data      <= '0;
      rd_WB        <= '0;
      RegWrite_WB  <= 1'b0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_exc <= misalign;
      bus_err      <= abort;
      if (state == ST_IDLE && !access) begin
        wb_data     <= alu_MEM;
        rd_WB       <= rd_MEM;
        RegWrite_WB <= wr_en;
      end else if (finish) begin
        wb_data     <= (MemtoReg_MEM && !is_store) ? ld_data : alu_MEM;
        rd_WB       <= rd_MEM;
        RegWrite_WB <= wr_en & ~is_store;
      end else begin
        RegWrite_WB <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: the driver computes expected
// write-back and memory-port behaviour from the access rules, a memory
// responder checks requests, a monitor checks each retirement.
module tb_mem_stage;

  localparam int TO = 4;
  localparam int WITHHELD = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_MEM = '0, rs2_mem_data_MEM = '0;
  logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0;
  logic        RegWrite_MEM = 1'b0, MemtoReg_MEM = 1'b0;
  logic [4:0]  rd_MEM = '0;
  logic [2:0]  funct3_MEM = '0;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, RegWrite_WB, misalign_exc, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  rd_WB;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .alu_MEM(alu_MEM), .rs2_mem_data_MEM(rs2_mem_data_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
    .rd_MEM(rd_MEM), .funct3_MEM(funct3_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_data(wb_data), .rd_WB(rd_WB),
    .RegWrite_WB(RegWrite_WB), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        chk;
    logic        mis;
    logic        berr;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mreq_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  valid = 1'b0, mon_en = 1'b1, resp_en = 1'b0, man_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an instruction retires at every edge where it was not stalled
  initial begin : monitor
    logic prev_stall, prev_valid;
    exp_t e;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && prev_valid) begin
        if (!prev_stall) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL retire: got retirement expected empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            check("RegWrite_WB", 32'(RegWrite_WB), 32'(e.rw));
            check("misalign_exc", 32'(misalign_exc), 32'(e.mis));
            check("bus_err", 32'(bus_err), 32'(e.berr));
            if (e.chk) begin
              check("wb_data", wb_data, e.wb);
              check("rd_WB", 32'(rd_WB), 32'(e.rd));
            end
          end
        end else begin
          check("bubble_RegWrite_WB", 32'(RegWrite_WB), 32'(0));
          check("bubble_misalign", 32'(misalign_exc), 32'(0));
          check("bubble_bus_err", 32'(bus_err), 32'(0));
        end
      end
      prev_stall = mem_stall;
      prev_valid = valid;
    end
  end

  // Memory responder: checks each new request and its stability, acks after
  // the scripted number of WAIT cycles
  initial begin : responder
    mreq_t       cur;
    logic        active;
    int          w;
    logic        c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    active = 1'b0;
    w = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!resp_en) begin
        dmem_ack = man_ack;
        dmem_rdata = '0;
        active = 1'b0;
      end else if (!dmem_req) begin
        active = 1'b0;
        dmem_ack = 1'b0;
      end else begin
        if (!active) begin
          if (mreq_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL dmem_req: got 1 expected 0");
            cur.delay = 0;
            cur.rdata = '0;
          end else begin
            cur = mreq_q.pop_front();
            check("dmem_we", 32'(dmem_we), 32'(cur.we));
            check("dmem_addr", dmem_addr, cur.addr);
            if (cur.we) begin
              check("dmem_be", 32'(dmem_be), 32'(cur.be));
              check("dmem_wdata", dmem_wdata, cur.wdata);
            end
          end
          c_we = dmem_we; c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata;
          active = 1'b1;
          w = 0;
        end else begin
          check("stable_we", 32'(dmem_we), 32'(c_we));
          check("stable_addr", dmem_addr, c_addr);
          check("stable_be", 32'(dmem_be), 32'(c_be));
          check("stable_wdata", dmem_wdata, c_wdata);
        end
        dmem_ack = (w == cur.delay);
        dmem_rdata = dmem_ack ? cur.rdata : $urandom();
        w++;
      end
    end
  end

  // Reference model of one instruction, then drive it and hold while stalled
  task automatic issue(input logic [31:0] a, input logic [31:0] d2,
                       input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] rdata, input int delay);
    exp_t        e;
    mreq_t       m;
    int          sz, off, v, exp_stalls, stalls;
    logic [31:0] lane;
    off = int'(a[1:0]);
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.wb = '0; e.rd = rd; e.rw = 1'b0; e.chk = 1'b0; e.mis = 1'b0; e.berr = 1'b0;
    exp_stalls = 0;
    if (!(mr || mw)) begin
      e.wb = a; e.rw = rw && (rd != 0); e.chk = 1'b1;
    end else if (off % sz != 0) begin
      e.mis = 1'b1;
    end else begin
      m.we    = mw;
      m.addr  = a - 32'(off);
      m.be    = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
      m.wdata = (sz == 1) ? (d2 & 32'd255) * 32'h0101_0101 :
                (sz == 2) ? (d2 & 32'd65535) * 32'h0001_0001 : d2;
      m.rdata = rdata;
      m.delay = delay;
      mreq_q.push_back(m);
      if (delay > TO) begin
        e.berr = 1'b1;
        exp_stalls = 1 + TO;
      end else begin
        exp_stalls = 1 + delay;
        if (!mw) begin
          e.rw = rw && (rd != 0);
          e.chk = 1'b1;
          lane = rdata >> (8 * off);
          if (!m2r) e.wb = a;
          else case (f3)
            3'd0: begin v = int'(lane & 32'd255);   if (v > 127)   v -= 256;   e.wb = 32'(v); end
            3'd1: begin v = int'(lane & 32'd65535); if (v > 32767) v -= 65536; e.wb = 32'(v); end
            3'd4: e.wb = lane & 32'd255;
            3'd5: e.wb = lane & 32'd65535;
            default: e.wb = rdata;
          endcase
        end
      end
    end
    exp_q.push_back(e);
    alu_MEM = a; rs2_mem_data_MEM = d2; MemRead_MEM = mr; MemWrite_MEM = mw;
    RegWrite_MEM = rw; MemtoReg_MEM = m2r; rd_MEM = rd; funct3_MEM = f3;
    valid = 1'b1;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (stalls > 300) begin
        n_chk++; n_fail++;
        $display("FAIL stall_bound: got >300 stall cycles expected %0d", exp_stalls);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "stall never released");
      end
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    alu_MEM = '0; rs2_mem_data_MEM = '0; MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0;
    RegWrite_MEM = 1'b0; MemtoReg_MEM = 1'b0; rd_MEM = '0; funct3_MEM = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          kind, dly;
    logic [31:0] a, d2, rdat;
    logic [2:0]  f3;
    logic        mr, mw;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'(0));
    check("rst_dmem_we", 32'(dmem_we), 32'(0));
    check("rst_dmem_addr", dmem_addr, 32'(0));
    check("rst_dmem_be", 32'(dmem_be), 32'(0));
    check("rst_dmem_wdata", dmem_wdata, 32'(0));
    check("rst_wb_data", wb_data, 32'(0));
    check("rst_rd_WB", 32'(rd_WB), 32'(0));
    check("rst_RegWrite_WB", 32'(RegWrite_WB), 32'(0));
    check("rst_misalign", 32'(misalign_exc), 32'(0));
    check("rst_bus_err", 32'(bus_err), 32'(0));
    check("rst_mem_stall", 32'(mem_stall), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    resp_en = 1'b1;

    // directed cases
    issue(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 3'd0, 32'h0, 0);         // ALU op
    issue(32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 3'd0, 32'h80FF_FF00, 1);   // LB, ack 1 cycle late
    issue(32'h202, 32'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 3'd1, 32'h0, 0);        // SH upper half
    issue(32'h101, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 3'd2, 32'h0, 0);           // LW misaligned
    issue(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'd2, 32'h0, WITHHELD);    // LW timeout
    issue(32'h404, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 3'd2, 32'h1111_2222, 0);   // rd=0 load
    issue(32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 3'd5, 32'h8765_4321, 2);    // LHU offset 0
    issue(32'hA, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 3'd1, 32'h8765_4321, 0);    // LH offset 2

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      d2 = $urandom();
      rdat = $urandom();
      dly = ($urandom_range(0, 11) == 0) ? WITHHELD : int'($urandom_range(0, 3));
      mr = 1'b0; mw = 1'b0;
      f3 = 3'($urandom_range(0, 2));
      if (kind >= 3 && kind <= 5) mr = 1'b1;
      if (kind == 9) begin mr = 1'b1; f3 = 3'($urandom_range(0, 7)); end
      if (kind == 6 || kind == 7) mw = 1'b1;
      if (kind == 8) begin mr = 1'b1; mw = 1'b1; end
      issue(a, d2, mr, mw, ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) != 0),
            5'($urandom_range(0, 31)), f3, rdat, dly);
    end
    valid = 1'b0;
    bubble();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("requests_drained", 32'(mreq_q.size()), 32'(0));

    // reset while waiting, then a late ack
    mon_en = 1'b0;
    resp_en = 1'b0;
    man_ack = 1'b0;
    alu_MEM = 32'h40; MemRead_MEM = 1'b1; RegWrite_MEM = 1'b1; MemtoReg_MEM = 1'b1;
    rd_MEM = 5'd7; funct3_MEM = 3'd2;
    @(posedge clk); #1;
    check("rstw_req_up", 32'(dmem_req), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    man_ack = 1'b1;
    @(posedge clk); #1;
    check("rstw_req", 32'(dmem_req), 32'(0));
    check("rstw_wb_data", wb_data, 32'(0));
    check("rstw_rd_WB", 32'(rd_WB), 32'(0));
    check("rstw_RegWrite_WB", 32'(RegWrite_WB), 32'(0));
    check("rstw_bus_err", 32'(bus_err), 32'(0));
    check("rstw_addr", dmem_addr, 32'(0));
    rst = 1'b1;
    bubble();
    @(posedge clk); #1;
    check("late_ack_req", 32'(dmem_req), 32'(0));
    check("late_ack_RegWrite_WB", 32'(RegWrite_WB), 32'(0));
    check("late_ack_wb_data", wb_data, 32'(0));
    check("late_ack_stall", 32'(mem_stall), 32'(0));
    man_ack = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
